// File: rtl/gpio_cfg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gpio_cfg_pkg : shared defaults, config-word field layout and FSM encoding
// Revision 1.0
// ---------------------------------------------------------------------------
package gpio_cfg_pkg;

    localparam int NUM_PADS_DEF = 27;
    localparam int CFG_BITS_DEF = 13;
    localparam int CLK_DIV_DEF  = 4;

    // Per-pad control word layout as seen by the GPIO control blocks
    localparam int CFG_MGMT_EN_OFF   = 0;
    localparam int CFG_OUT_DIS_OFF   = 1;
    localparam int CFG_HOLD_OVR_OFF  = 2;
    localparam int CFG_INP_DIS_OFF   = 3;
    localparam int CFG_IB_MODE_OFF   = 4;
    localparam int CFG_ANA_EN_OFF    = 5;
    localparam int CFG_ANA_SEL_OFF   = 6;
    localparam int CFG_ANA_POL_OFF   = 7;
    localparam int CFG_SLOW_SEL_OFF  = 8;
    localparam int CFG_VTRIP_SEL_OFF = 9;
    localparam int CFG_DM_OFF        = 10;
    localparam int CFG_DM_W          = 3;

    localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
    localparam logic [2:0] ST_FETCH_ENC    = 3'd1;
    localparam logic [2:0] ST_CAPT_ENC     = 3'd2;
    localparam logic [2:0] ST_SHIFT_LO_ENC = 3'd3;
    localparam logic [2:0] ST_SHIFT_HI_ENC = 3'd4;
    localparam logic [2:0] ST_LOAD_ENC     = 3'd5;
    localparam logic [2:0] ST_DONE_ENC     = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE     = ST_IDLE_ENC,
        ST_FETCH    = ST_FETCH_ENC,
        ST_CAPT     = ST_CAPT_ENC,
        ST_SHIFT_LO = ST_SHIFT_LO_ENC,
        ST_SHIFT_HI = ST_SHIFT_HI_ENC,
        ST_LOAD     = ST_LOAD_ENC,
        ST_DONE     = ST_DONE_ENC
    } state_e;

endpackage
`default_nettype wire

// File: rtl/gpio_cfg_phase_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gpio_cfg_phase_timer : 0..CLK_DIV-1 phase counter with reload and terminal count
// Revision 1.0
// ---------------------------------------------------------------------------
module gpio_cfg_phase_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic reload_i,
    output logic tc_o
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign tc_o = (cnt_q == TW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + TW'(1);
        if (reload_i || tc_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gpio_cfg_serial_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gpio_cfg_serial_loader : streams per-pad config words into the GPIO control chain
// Revision 1.0
// ---------------------------------------------------------------------------
module gpio_cfg_serial_loader
    import gpio_cfg_pkg::*;
#(
    parameter int NUM_PADS = NUM_PADS_DEF,
    parameter int CFG_BITS = CFG_BITS_DEF,
    parameter int CLK_DIV  = CLK_DIV_DEF,
    localparam int AW      = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1,
    localparam int BW      = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                start,
    output logic                cfg_rd,
    output logic [AW-1:0]       cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_data,
    output logic                serial_clock,
    output logic                serial_data,
    output logic                serial_load,
    output logic                busy,
    output logic                done
);

    state_e              state_q, state_d;
    logic [AW-1:0]       pad_q, pad_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [CFG_BITS-1:0] shreg_q, shreg_d;
    logic                w_phase_tc;
    logic                w_phase_reload;

    // Every state entry starts a fresh phase, so word gaps never skew timing
    assign w_phase_reload = (state_d != state_q);

    gpio_cfg_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_timer (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .reload_i (w_phase_reload),
        .tc_o     (w_phase_tc)
    );

    always_comb begin
        state_d = state_q;
        pad_d   = pad_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pad_d   = AW'(NUM_PADS - 1);
                end
            end
            ST_FETCH: state_d = ST_CAPT;
            ST_CAPT: begin
                shreg_d = cfg_data;
                bit_d   = BW'(CFG_BITS - 1);
                state_d = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                if (w_phase_tc) begin
                    state_d = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (w_phase_tc) begin
                    shreg_d = shreg_q << 1;
                    if (bit_q != '0) begin
                        bit_d   = bit_q - BW'(1);
                        state_d = ST_SHIFT_LO;
                    end else if (pad_q != '0) begin
                        pad_d   = pad_q - AW'(1);
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (w_phase_tc) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            pad_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            pad_q   <= pad_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    // Outputs decode straight from state so an async reset clears them at once
    assign cfg_rd       = (state_q == ST_FETCH);
    assign cfg_addr     = (state_q == ST_FETCH) ? pad_q : '0;
    assign serial_clock = (state_q == ST_SHIFT_HI);
    assign serial_data  = ((state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI))
                          ? shreg_q[CFG_BITS-1] : 1'b0;
    assign serial_load  = (state_q == ST_LOAD);
    assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done         = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_gpio_cfg_serial_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gpio_cfg_serial_loader : default-size and tiny-size loaders against a chain model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_gpio_cfg_serial_loader;

    localparam int NP   = 27;
    localparam int CB   = 13;
    localparam int CD   = 4;
    localparam int RUN  = NP * (2 + 2 * CD * CB) + CD;
    localparam int NPB  = 2;
    localparam int CBB  = 3;
    localparam int CDB  = 1;
    localparam int RUNB = NPB * (2 + 2 * CDB * CBB) + CDB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a, start_a, rd_a, sc_a, sd_a, sl_a, busy_a, done_a;
    logic [4:0]    addr_a;
    logic [CB-1:0] data_a;
    logic          rst_b, start_b, rd_b, sc_b, sd_b, sl_b, busy_b, done_b;
    logic [0:0]    addr_b;
    logic [CBB-1:0] data_b;

    logic [CB-1:0]  mem_a [NP];
    logic [CBB-1:0] mem_b [NPB];

    gpio_cfg_serial_loader #(.NUM_PADS(NP), .CFG_BITS(CB), .CLK_DIV(CD)) u_dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst_a), .start(start_a), .cfg_rd(rd_a),
        .cfg_addr(addr_a), .cfg_data(data_a), .serial_clock(sc_a),
        .serial_data(sd_a), .serial_load(sl_a), .busy(busy_a), .done(done_a));

    gpio_cfg_serial_loader #(.NUM_PADS(NPB), .CFG_BITS(CBB), .CLK_DIV(CDB)) u_dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst_b), .start(start_b), .cfg_rd(rd_b),
        .cfg_addr(addr_b), .cfg_data(data_b), .serial_clock(sc_b),
        .serial_data(sd_b), .serial_load(sl_b), .busy(busy_b), .done(done_b));

    // Config stores: data valid the cycle after the read strobe
    always @(posedge clk) if (rd_a) data_a <= mem_a[addr_a];
    always @(posedge clk) if (rd_b) data_b <= mem_b[addr_b];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Chain model for the default-size DUT: shifts on serial_clock rise, latches on load
    logic [NP*CB-1:0] chain_a = '0;
    logic [NP*CB-1:0] latched_a = '0;
    logic sc_prev_a = 1'b0, sd_prev_a = 1'b0, sl_prev_a = 1'b0;
    int cyc = 0, first_busy = -1, done_cyc = -1, exp_addr_a = NP - 1;
    int busy_cyc_a = 0, done_cnt_a = 0, load_cyc_a = 0, load_pulses_a = 0;

    always @(negedge clk) begin
        cyc++;
        if (sc_a && !sc_prev_a) chain_a = {chain_a[NP*CB-2:0], sd_a};
        if (sc_a && sc_prev_a) chk("a_sd_stable_while_sc_high", 64'(sd_a), 64'(sd_prev_a));
        if (sl_a) begin
            chk("a_sc_low_during_load", 64'(sc_a), 64'(0));
            load_cyc_a++;
            if (!sl_prev_a) load_pulses_a++;
            latched_a = chain_a;
        end
        if (!busy_a) exp_addr_a = NP - 1;
        if (rd_a) begin
            chk("a_cfg_addr_seq", 64'(addr_a), 64'(exp_addr_a));
            exp_addr_a--;
        end
        if (busy_a) begin
            busy_cyc_a++;
            if (first_busy < 0) first_busy = cyc;
        end
        if (done_a) begin
            done_cnt_a++;
            done_cyc = cyc;
        end
        sc_prev_a = sc_a;
        sd_prev_a = sd_a;
        sl_prev_a = sl_a;
    end

    task automatic clear_a();
        busy_cyc_a = 0; done_cnt_a = 0; load_cyc_a = 0; load_pulses_a = 0;
        first_busy = -1; done_cyc = -1;
    endtask

    task automatic run_a(input int repulse_at);
        clear_a();
        start_a = 1'b1;
        for (int c = 0; c < RUN + 40 && done_cnt_a == 0; c++) begin
            @(negedge clk); #1;
            start_a = (c == repulse_at);
        end
        start_a = 1'b0;
        chk("a_done_within_budget", 64'(done_cnt_a > 0), 64'(1));
        repeat (10) begin @(negedge clk); #1; end
    endtask

    task automatic check_run_a(input string tag);
        chk({tag, "_done_pulses"}, 64'(done_cnt_a), 64'(1));
        chk({tag, "_fetch_to_done"}, 64'(done_cyc - first_busy), 64'(RUN));
        chk({tag, "_busy_cycles"}, 64'(busy_cyc_a), 64'(RUN));
        chk({tag, "_load_pulses"}, 64'(load_pulses_a), 64'(1));
        chk({tag, "_load_width"}, 64'(load_cyc_a), 64'(CD));
        chk({tag, "_idle_after"}, 64'({busy_a, done_a, sl_a, sc_a}), 64'(0));
        for (int p = 0; p < NP; p++)
            chk($sformatf("%s_pad%0d_word", tag, p), 64'(latched_a[p*CB +: CB]), 64'(mem_a[p]));
    endtask

    // Tiny DUT: expected stream is simply pad1's word then pad0's word, MSB first
    task automatic run_b(input logic [2:0] w0, input logic [2:0] w1,
                         input logic [5:0] seq, input int idx);
        logic [63:0] sc_act, sc_exp;
        logic [5:0] sd_act;
        logic sc_prev, sd_prev;
        int nl, cycles, exp_addr;
        bit seen;
        mem_b[0] = w0; mem_b[1] = w1;
        sc_act = '0; sd_act = '0; sc_prev = 1'b0; sd_prev = 1'b0;
        nl = 0; cycles = 0; seen = 0; exp_addr = NPB - 1;
        start_b = 1'b1;
        for (int c = 0; c < RUNB + 20 && !seen; c++) begin
            @(negedge clk); #1;
            start_b = 1'b0;
            if (done_b) seen = 1;
            else if (busy_b) begin
                cycles++;
                sc_act = {sc_act[62:0], sc_b};
                if (sl_b) begin
                    nl++;
                    chk($sformatf("b%0d_sc_low_in_load", idx), 64'(sc_b), 64'(0));
                end
                if (sc_b && !sc_prev) sd_act = {sd_act[4:0], sd_b};
                if (sc_b && sc_prev)
                    chk($sformatf("b%0d_sd_stable", idx), 64'(sd_b), 64'(sd_prev));
                if (rd_b) begin
                    chk($sformatf("b%0d_cfg_addr", idx), 64'(addr_b), 64'(exp_addr));
                    exp_addr--;
                end
            end
            sc_prev = sc_b;
            sd_prev = sd_b;
        end
        sc_exp = '0;
        for (int p = 0; p < NPB; p++) begin
            sc_exp = sc_exp << 2;
            for (int b = 0; b < CBB; b++) begin
                for (int k = 0; k < CDB; k++) sc_exp = {sc_exp[62:0], 1'b0};
                for (int k = 0; k < CDB; k++) sc_exp = {sc_exp[62:0], 1'b1};
            end
        end
        sc_exp = sc_exp << CDB;
        chk($sformatf("b%0d_done_seen", idx), 64'(seen), 64'(1));
        chk($sformatf("b%0d_serial_stream", idx), 64'(sd_act), 64'(seq));
        chk($sformatf("b%0d_sclk_trace", idx), sc_act, sc_exp);
        chk($sformatf("b%0d_run_cycles", idx), 64'(cycles), 64'(RUNB));
        chk($sformatf("b%0d_load_width", idx), 64'(nl), 64'(CDB));
        @(negedge clk); #1;
        chk($sformatf("b%0d_idle_after", idx), 64'({busy_b, done_b}), 64'(0));
    endtask

    typedef struct {
        logic [2:0] w0;
        logic [2:0] w1;
        logic [5:0] seq;
    } vec_t;

    vec_t tbl [8];
    logic [NP*CB-1:0] saved_latch;

    initial begin
        tbl[0] = '{w0: 3'b101, w1: 3'b010, seq: 6'b010_101};
        tbl[1] = '{w0: 3'b111, w1: 3'b000, seq: 6'b000_111};
        tbl[2] = '{w0: 3'b001, w1: 3'b100, seq: 6'b100_001};
        tbl[3] = '{w0: 3'b110, w1: 3'b011, seq: 6'b011_110};
        for (int i = 4; i < 8; i++) begin
            tbl[i].w0  = 3'($urandom);
            tbl[i].w1  = 3'($urandom);
            tbl[i].seq = {tbl[i].w1, tbl[i].w0};
        end

        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs_a", 64'({rd_a, addr_a, sc_a, sd_a, sl_a, busy_a, done_a}), 64'(0));
        chk("reset_outputs_b", 64'({rd_b, addr_b, sc_b, sd_b, sl_b, busy_b, done_b}), 64'(0));
        rst_a = 1'b0; rst_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            chk("idle_outputs_a", 64'({rd_a, addr_a, sc_a, sd_a, sl_a, busy_a, done_a}), 64'(0));
        end

        for (int i = 0; i < NP; i++) mem_a[i] = CB'(13'h1000 | i);
        run_a(-1);
        check_run_a("full_load");

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NP; i++) mem_a[i] = CB'($urandom);
            run_a(-1);
            check_run_a($sformatf("rand%0d", r));
        end

        for (int i = 0; i < NP; i++) mem_a[i] = CB'($urandom);
        run_a(100);
        check_run_a("repulse");

        // Abort mid-word at pad 13, bit 6, while serial_clock is high
        saved_latch = latched_a;
        for (int i = 0; i < NP; i++) mem_a[i] = CB'($urandom);
        clear_a();
        start_a = 1'b1;
        @(negedge clk); #1;
        start_a = 1'b0;
        repeat (13 * (2 + 2 * CD * CB) + 2 + 6 * 2 * CD + CD + 2) @(negedge clk);
        #1;
        chk("pre_abort_sclk_high", 64'(sc_a), 64'(1));
        #2 rst_a = 1'b1;
        #1;
        chk("abort_outputs_zero", 64'({rd_a, addr_a, sc_a, sd_a, sl_a, busy_a, done_a}), 64'(0));
        repeat (3) @(negedge clk);
        #1 rst_a = 1'b0;
        repeat (5) begin @(negedge clk); #1; end
        chk("abort_no_load", 64'(load_pulses_a), 64'(0));
        chk("abort_no_done", 64'(done_cnt_a), 64'(0));
        chk("abort_chain_kept", 64'(latched_a == saved_latch), 64'(1));

        for (int i = 0; i < NP; i++) mem_a[i] = CB'($urandom);
        run_a(-1);
        check_run_a("after_abort");

        for (int i = 0; i < 8; i++) begin
            run_b(tbl[i].w0, tbl[i].w1, tbl[i].seq, i);
            repeat (2) @(negedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
